// File: rtl/spi_reg_bank_n.sv
// spi_reg_bank_n
//   SPI slave register file. It decodes two-word frames (a header, then a data
//   word) from the SPI shifter into register writes and reads. PWM period and
//   width registers are double-buffered: writes land in shadows, and a write to
//   address 0xFF copies every shadow to the active outputs in one edge. The
//   block also keeps saturating error counters for frame timeouts, SPI clock
//   errors and illegal headers.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   rx_data_ready/_data strobe plus received 16-bit word from the shifter
//   tx_data_ready/_data strobe plus read-back word to the shifter
//   board_id, version   static identification inputs (read-only registers)
//   rc_pwidth           RC pulse widths, channel i at [16i+15:16i]
//   spi_clk_error       level error flag from the shifter, edge counted
//   cpu_mode, control   plain R/W configuration outputs
//   pwm_period/_width   active (committed) PWM settings
//   load_pulse          one-cycle pulse after a commit
//   frame_lost_error    one-cycle pulse after a header/data timeout
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a header word
// ST_WRITE | write header accepted, waiting for the data word
// ST_READ  | read header accepted, waiting for the (ignored) data word
module spi_reg_bank_n #(
    parameter int          NUM_PWM         = 8,
    parameter int          NUM_RC          = 6,
    parameter int          FRAME_LOST_TIME = 2400,
    parameter logic [15:0] PWM_PERIOD_RST  = 16'd20000,
    parameter logic [15:0] PWM_WIDTH_RST   = 16'd1500
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_data_ready,
    input  logic [15:0]           rx_data,
    output logic                  tx_data_ready,
    output logic [15:0]           tx_data,
    input  logic [3:0]            board_id,
    input  logic [31:0]           version,
    input  logic [16*NUM_RC-1:0]  rc_pwidth,
    input  logic                  spi_clk_error,
    output logic [3:0]            cpu_mode,
    output logic [15:0]           control,
    output logic [15:0]           pwm_period,
    output logic [16*NUM_PWM-1:0] pwm_width,
    output logic                  load_pulse,
    output logic                  frame_lost_error
);

    localparam int TMO_W = (FRAME_LOST_TIME < 1) ? 1 : $clog2(FRAME_LOST_TIME + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(FRAME_LOST_TIME);

    localparam logic [7:0] A_BOARD_ID = 8'h01;
    localparam logic [7:0] A_CONTROL  = 8'h03;
    localparam logic [7:0] A_CPU_MODE = 8'h05;
    localparam logic [7:0] A_ILLEGAL  = 8'h1C;
    localparam logic [7:0] A_VER_LO   = 8'h1D;
    localparam logic [7:0] A_VER_HI   = 8'h1E;
    localparam logic [7:0] A_STATUS   = 8'h1F;
    localparam logic [7:0] A_PERIOD   = 8'h40;
    localparam logic [7:0] A_LOAD     = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    state_t                  state_q;
    logic [7:0]              addr_q;
    logic [TMO_W-1:0]        tmo_q;
    logic                    rd_pend_q;
    logic [15:0]             tx_data_q;
    logic                    tx_rdy_q;
    logic [3:0]              cpu_mode_q;
    logic [15:0]             control_q;
    logic [15:0]             period_sh_q;
    logic [15:0]             pwm_period_q;
    logic [16*NUM_PWM-1:0]   width_sh_q;
    logic [16*NUM_PWM-1:0]   pwm_width_q;
    logic [7:0]              illegal_cnt_q, illegal_cnt_d;
    logic [7:0]              lost_cnt_q,    lost_cnt_d;
    logic [7:0]              clkerr_cnt_q,  clkerr_cnt_d;
    logic                    clk_err_q;
    logic                    load_pulse_q;
    logic                    frame_lost_q;

    logic                    hdr_legal;
    logic                    in_frame;
    logic                    timeout;
    logic                    wr_strobe;
    logic                    status_clr;
    logic                    commit;
    logic                    illegal_hdr;
    logic                    clk_err_rise;
    logic [15:0]             rd_data;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign hdr_legal    = (rx_data[15:14] == 2'b00) || (rx_data[15:14] == 2'b11);
    assign in_frame     = (state_q != ST_IDLE);
    // A data word arriving on the timeout edge takes priority over the timeout.
    assign timeout      = in_frame && !rx_data_ready && (tmo_q == TMO_LAST);
    assign wr_strobe    = (state_q == ST_WRITE) && rx_data_ready;
    assign status_clr   = wr_strobe && (addr_q == A_STATUS);
    assign commit       = wr_strobe && (addr_q == A_LOAD);
    assign illegal_hdr  = (state_q == ST_IDLE) && rx_data_ready && !hdr_legal;
    assign clk_err_rise = spi_clk_error && !clk_err_q;

    // Saturating counters; a status clear overrides a coincident increment.
    always_comb begin
        illegal_cnt_d = illegal_cnt_q;
        lost_cnt_d    = lost_cnt_q;
        clkerr_cnt_d  = clkerr_cnt_q;
        if (illegal_hdr) begin
            illegal_cnt_d = sat_inc(illegal_cnt_q);
        end
        if (timeout) begin
            lost_cnt_d = sat_inc(lost_cnt_q);
        end
        if (clk_err_rise) begin
            clkerr_cnt_d = sat_inc(clkerr_cnt_q);
        end
        if (status_clr) begin
            lost_cnt_d   = 8'h00;
            clkerr_cnt_d = 8'h00;
        end
    end

    // Read-back mux. PWM addresses return the shadow, not the active value.
    always_comb begin
        rd_data = 16'h0000;
        case (addr_q)
            A_BOARD_ID: rd_data = {12'h000, board_id};
            A_CONTROL:  rd_data = control_q;
            A_CPU_MODE: rd_data = {12'h000, cpu_mode_q};
            A_ILLEGAL:  rd_data = {8'h00, illegal_cnt_q};
            A_VER_LO:   rd_data = version[15:0];
            A_VER_HI:   rd_data = version[31:16];
            A_STATUS:   rd_data = {lost_cnt_q, clkerr_cnt_q};
            A_PERIOD:   rd_data = period_sh_q;
            default: begin
                for (int i = 0; i < NUM_PWM; i++) begin
                    if (addr_q == 8'(8'h41 + i)) begin
                        rd_data = width_sh_q[16*i +: 16];
                    end
                end
                for (int i = 0; i < NUM_RC; i++) begin
                    if (addr_q == 8'(8'h80 + i)) begin
                        rd_data = rc_pwidth[16*i +: 16];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            addr_q        <= 8'h00;
            tmo_q         <= '0;
            rd_pend_q     <= 1'b0;
            tx_data_q     <= 16'h0000;
            tx_rdy_q      <= 1'b0;
            cpu_mode_q    <= 4'h0;
            control_q     <= 16'h0000;
            period_sh_q   <= PWM_PERIOD_RST;
            pwm_period_q  <= PWM_PERIOD_RST;
            width_sh_q    <= {NUM_PWM{PWM_WIDTH_RST}};
            pwm_width_q   <= {NUM_PWM{PWM_WIDTH_RST}};
            illegal_cnt_q <= 8'h00;
            lost_cnt_q    <= 8'h00;
            clkerr_cnt_q  <= 8'h00;
            clk_err_q     <= 1'b0;
            load_pulse_q  <= 1'b0;
            frame_lost_q  <= 1'b0;
        end else begin
            clk_err_q     <= spi_clk_error;
            illegal_cnt_q <= illegal_cnt_d;
            lost_cnt_q    <= lost_cnt_d;
            clkerr_cnt_q  <= clkerr_cnt_d;
            load_pulse_q  <= commit;
            frame_lost_q  <= timeout;

            // Read data is fetched one edge after the header so the latched
            // address drives the mux; tx_data then holds until the next read.
            rd_pend_q <= 1'b0;
            tx_rdy_q  <= 1'b0;
            if (rd_pend_q) begin
                tx_data_q <= rd_data;
                tx_rdy_q  <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (rx_data_ready && hdr_legal) begin
                        addr_q <= rx_data[7:0];
                        tmo_q  <= '0;
                        if (rx_data[15]) begin
                            state_q   <= ST_READ;
                            rd_pend_q <= 1'b1;
                        end else begin
                            state_q <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE, ST_READ: begin
                    if (rx_data_ready) begin
                        state_q <= ST_IDLE;
                        if (state_q == ST_WRITE) begin
                            case (addr_q)
                                A_CONTROL:  control_q   <= rx_data;
                                A_CPU_MODE: cpu_mode_q  <= rx_data[3:0];
                                A_PERIOD:   period_sh_q <= rx_data;
                                A_LOAD: begin
                                    pwm_period_q <= period_sh_q;
                                    pwm_width_q  <= width_sh_q;
                                end
                                default: begin
                                    for (int i = 0; i < NUM_PWM; i++) begin
                                        if (addr_q == 8'(8'h41 + i)) begin
                                            width_sh_q[16*i +: 16] <= rx_data;
                                        end
                                    end
                                end
                            endcase
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        state_q <= ST_IDLE;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign tx_data_ready    = tx_rdy_q;
    assign tx_data          = tx_data_q;
    assign cpu_mode         = cpu_mode_q;
    assign control          = control_q;
    assign pwm_period       = pwm_period_q;
    assign pwm_width        = pwm_width_q;
    assign load_pulse       = load_pulse_q;
    assign frame_lost_error = frame_lost_q;

endmodule

// File: tb/tb_spi_reg_bank_n.sv
module tb_spi_reg_bank_n;

    localparam int NP  = 32;
    localparam int NR  = 16;
    localparam int FLT = 2400;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              rx_data_ready = 1'b0;
    logic [15:0]       rx_data = 16'h0000;
    logic              tx_data_ready;
    logic [15:0]       tx_data;
    logic [3:0]        board_id;
    logic [31:0]       version;
    logic [16*NR-1:0]  rc_pwidth;
    logic              spi_clk_error = 1'b0;
    logic [3:0]        cpu_mode;
    logic [15:0]       control;
    logic [15:0]       pwm_period;
    logic [16*NP-1:0]  pwm_width;
    logic              load_pulse;
    logic              frame_lost_error;

    spi_reg_bank_n #(
        .NUM_PWM(NP), .NUM_RC(NR), .FRAME_LOST_TIME(FLT),
        .PWM_PERIOD_RST(16'd20000), .PWM_WIDTH_RST(16'd1500)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_data_ready(rx_data_ready), .rx_data(rx_data),
        .tx_data_ready(tx_data_ready), .tx_data(tx_data),
        .board_id(board_id), .version(version), .rc_pwidth(rc_pwidth),
        .spi_clk_error(spi_clk_error),
        .cpu_mode(cpu_mode), .control(control),
        .pwm_period(pwm_period), .pwm_width(pwm_width),
        .load_pulse(load_pulse), .frame_lost_error(frame_lost_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check16(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic checki(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic checkw(input string name, input logic [16*NP-1:0] got, input logic [16*NP-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference model: register map as plain variables.
    logic [15:0] m_ctrl;
    logic [3:0]  m_cpu;
    logic [15:0] m_psh, m_pact;
    logic [15:0] m_wsh [NP];
    logic [15:0] m_wact[NP];
    int          m_ill, m_lost, m_clk;
    int          m_lp = 0;
    int          fl_exp = 0;
    int          lp_seen = 0;
    int          fl_seen = 0;

    function automatic int sat(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    task automatic m_reset();
        m_ctrl = 16'h0; m_cpu = 4'h0;
        m_psh = 16'd20000; m_pact = 16'd20000;
        for (int i = 0; i < NP; i++) begin
            m_wsh[i] = 16'd1500; m_wact[i] = 16'd1500;
        end
        m_ill = 0; m_lost = 0; m_clk = 0;
    endtask

    function automatic logic [16*NP-1:0] m_width_vec();
        logic [16*NP-1:0] v;
        for (int i = 0; i < NP; i++) v[16*i +: 16] = m_wact[i];
        return v;
    endfunction

    function automatic logic [15:0] m_read(input logic [7:0] a);
        if (a == 8'h01) return {12'h0, board_id};
        if (a == 8'h03) return m_ctrl;
        if (a == 8'h05) return {12'h0, m_cpu};
        if (a == 8'h1C) return {8'h0, 8'(m_ill)};
        if (a == 8'h1D) return version[15:0];
        if (a == 8'h1E) return version[31:16];
        if (a == 8'h1F) return {8'(m_lost), 8'(m_clk)};
        if (a == 8'h40) return m_psh;
        if (int'(a) >= 'h41 && int'(a) < 'h41 + NP) return m_wsh[int'(a) - 'h41];
        if (int'(a) >= 'h80 && int'(a) < 'h80 + NR) return rc_pwidth[16*(int'(a) - 'h80) +: 16];
        return 16'h0000;
    endfunction

    task automatic m_write(input logic [7:0] a, input logic [15:0] d);
        if (a == 8'h03) m_ctrl = d;
        else if (a == 8'h05) m_cpu = d[3:0];
        else if (a == 8'h1F) begin m_lost = 0; m_clk = 0; end
        else if (a == 8'h40) m_psh = d;
        else if (a == 8'hFF) begin
            m_pact = m_psh;
            for (int i = 0; i < NP; i++) m_wact[i] = m_wsh[i];
            m_lp++;
        end else if (int'(a) >= 'h41 && int'(a) < 'h41 + NP) m_wsh[int'(a) - 'h41] = d;
    endtask

    task automatic check_outputs(input string tag);
        check16({tag, "_control"}, control, m_ctrl);
        checki({tag, "_cpu_mode"}, int'(cpu_mode), int'(m_cpu));
        check16({tag, "_pwm_period"}, pwm_period, m_pact);
        checkw({tag, "_pwm_width"}, pwm_width, m_width_vec());
    endtask

    // Scoreboard: expected read words are queued at issue, popped on tx_data_ready.
    logic [15:0] exp_q[$];
    logic        prev_rdy = 1'b0;

    always @(negedge clk) begin
        if (load_pulse) lp_seen++;
        if (frame_lost_error) fl_seen++;
        if (tx_data_ready) begin
            checki("tx_ready_single_cycle", int'(prev_rdy), 0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_unexpected: got read word %h, expected no read pending", tx_data);
            end else begin
                check16("read_data", tx_data, exp_q.pop_front());
            end
        end
        prev_rdy = tx_data_ready;
    end

    // All stimulus tasks start and end right after a negedge.
    task automatic send_word(input logic [15:0] w);
        rx_data = w;
        rx_data_ready = 1'b1;
        @(negedge clk);
        rx_data_ready = 1'b0;
        rx_data = 16'($urandom);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [15:0] d);
        send_word({2'b00, 6'($urandom), a});
        send_word(d);
        m_write(a, d);
        checki("load_pulse_after_write", int'(load_pulse), int'(a == 8'hFF));
        check_outputs("wr");
    endtask

    task automatic do_read(input logic [7:0] a);
        exp_q.push_back(m_read(a));
        send_word({2'b11, 6'($urandom), a});
        send_word(16'($urandom));
    endtask

    task automatic do_illegal();
        logic [1:0] op;
        op = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
        send_word({op, 6'($urandom), 8'($urandom)});
        m_ill = sat(m_ill);
    endtask

    function automatic logic [7:0] pick_addr();
        case ($urandom_range(0, 11))
            0:  return 8'($urandom);
            1:  return 8'h01;
            2:  return 8'h03;
            3:  return 8'h05;
            4:  return 8'h1C;
            5:  return 8'h1D;
            6:  return 8'h1E;
            7:  return 8'h1F;
            8:  return 8'h40;
            9:  return 8'('h41 + $urandom_range(0, NP));
            10: return 8'('h80 + $urandom_range(0, NR));
            default: return 8'hFF;
        endcase
    endfunction

    initial begin
        int k;
        board_id = 4'($urandom);
        version  = $urandom;
        for (int i = 0; i < NR; i++) rc_pwidth[16*i +: 16] = 16'($urandom);
        m_reset();

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check_outputs("reset");
        checki("reset_tx_ready", int'(tx_data_ready), 0);
        check16("reset_tx_data", tx_data, 16'h0000);
        checki("reset_load_pulse", int'(load_pulse), 0);
        checki("reset_frame_lost", int'(frame_lost_error), 0);
        do_read(8'h1F);

        // Double buffering
        do_write(8'h41, 16'd1800);
        do_write(8'h40, 16'd10000);
        check16("ch0_before_commit", pwm_width[15:0], 16'd1500);
        check16("period_before_commit", pwm_period, 16'd20000);
        do_read(8'h41);
        do_read(8'h40);
        do_write(8'hFF, 16'($urandom));
        check16("ch0_after_commit", pwm_width[15:0], 16'd1800);
        check16("period_after_commit", pwm_period, 16'd10000);
        @(negedge clk);
        checki("load_pulse_one_cycle", int'(load_pulse), 0);

        // Read latency
        do_write(8'h05, 16'h0003);
        exp_q.push_back(16'h0003);
        rx_data = 16'hC005; rx_data_ready = 1'b1;
        @(negedge clk);
        rx_data_ready = 1'b0;
        checki("rd_lat_hdr_cycle", int'(tx_data_ready), 0);
        rx_data = 16'($urandom); rx_data_ready = 1'b1;
        @(negedge clk);
        rx_data_ready = 1'b0;
        checki("rd_lat_next_cycle", int'(tx_data_ready), 1);
        check16("rd_lat_data", tx_data, 16'h0003);
        @(negedge clk);
        checki("rd_lat_drop", int'(tx_data_ready), 0);
        check16("rd_data_hold", tx_data, 16'h0003);
        do_read(8'('h80 + NR));
        do_read(8'h8F);
        do_read(8'h01);
        do_read(8'h1D);
        do_read(8'h1E);
        do_read(8'hFF);

        // Last channel only
        do_write(8'h60, 16'd1234);
        do_write(8'hFF, 16'($urandom));
        check16("ch31_after_commit", pwm_width[16*31 +: 16], 16'd1234);

        // Timeout with no data word
        send_word(16'h0003);
        for (k = 1; k <= 3000; k++) begin
            @(negedge clk);
            if (frame_lost_error) break;
        end
        checki("timeout_cycle", k, FLT + 1);
        m_lost = sat(m_lost);
        fl_exp++;
        @(negedge clk);
        checki("frame_lost_one_cycle", int'(frame_lost_error), 0);
        check_outputs("timeout");
        do_read(8'h1F);

        // Data word exactly on the timeout edge
        send_word(16'h0003);
        repeat (FLT) @(negedge clk);
        send_word(16'hA5C3);
        m_write(8'h03, 16'hA5C3);
        checki("boundary_no_lost", int'(frame_lost_error), 0);
        check_outputs("boundary");
        do_read(8'h1F);

        // clkerr saturation
        repeat (300) begin
            spi_clk_error = 1'b1; @(negedge clk);
            spi_clk_error = 1'b0; @(negedge clk);
            m_clk = sat(m_clk);
        end
        do_read(8'h1F);

        // Illegal header, FSM stays in IDLE
        send_word(16'h4001);
        m_ill = sat(m_ill);
        do_write(8'h03, 16'h1234);
        do_read(8'h1C);

        // Status clear
        do_write(8'h1F, 16'($urandom));
        do_read(8'h1F);
        do_read(8'h1C);

        // Clear coinciding with a clkerr increment
        spi_clk_error = 1'b1; @(negedge clk);
        spi_clk_error = 1'b0; @(negedge clk);
        m_clk = sat(m_clk);
        do_read(8'h1F);
        send_word(16'h001F);
        spi_clk_error = 1'b1;
        send_word(16'($urandom));
        m_write(8'h1F, 16'h0000);
        do_read(8'h1F);
        spi_clk_error = 1'b0;
        @(negedge clk);

        // Randomized traffic
        repeat (300) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: do_write(pick_addr(), 16'($urandom));
                5, 6, 7, 8:    do_read(pick_addr());
                default:       do_illegal();
            endcase
        end
        do_read(8'h1C);

        // Reset in the middle of a write frame
        send_word(16'h0003);
        rx_data = 16'hBEEF; rx_data_ready = 1'b1; rst_n = 1'b0;
        @(negedge clk);
        rx_data_ready = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        m_reset();
        check_outputs("mid_reset");
        do_write(8'h03, 16'h5A5A);
        do_read(8'h03);

        repeat (5) @(negedge clk);
        checki("scoreboard_drained", exp_q.size(), 0);
        checki("load_pulse_count", lp_seen, m_lp);
        checki("frame_lost_count", fl_seen, fl_exp);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_reg_bank_n.md
# spi_reg_bank_n

Parametrised SPI register bank, next generation of the CPLD's SPI slave register file. Sits between the SPI slave shifter (16-bit rx/tx words) and the PWM/RC/sonar blocks. Decodes two-word frames (header, then data) into writes and reads on a register map whose PWM and RC channel counts are set by parameters. Adds double-buffered PWM registers with an atomic commit, saturating error counters with clear-on-write, and illegal-header detection.

## Interface
- NUM_PWM, 8: PWM output channels, 1..32.
- NUM_RC, 6: RC pulse-width input channels, 1..16.
- FRAME_LOST_TIME, 2400: clk cycles allowed between header and data word.
- PWM_PERIOD_RST, 16'd20000: reset value of the shared PWM period.
- PWM_WIDTH_RST, 16'd1500: reset value of every PWM width.
- clk  in  1  system clock, single domain. Reset is asynchronous and active-low.
- rst_n  in  1  asynchronous active-low reset.
- rx_data_ready  in  1  one-cycle strobe: rx_data valid.
- rx_data  in  16  received word.
- tx_data_ready  out  1  one-cycle strobe: tx_data valid for the shifter.
- tx_data  out  16  read-back word.
- board_id  in  4  board identifier.
- version  in  32  build version.
- rc_pwidth  in  16*NUM_RC  RC widths, channel i at [16i+15:16i].
- spi_clk_error  in  1  level flag from the shifter.
- cpu_mode  out  4  CPU mode register.
- control  out  16  control register.
- pwm_period  out  16  active PWM period.
- pwm_width  out  16*NUM_PWM  active widths, channel i at [16i+15:16i].
- load_pulse  out  1  one-cycle pulse on commit (also the master watchdog).
- frame_lost_error  out  1  one-cycle pulse on frame timeout.

## Operation
- Header word: [15:14]=00 write, 11 read; [7:0] address. Headers 01/10 are illegal: no state change; illegal_cnt increments.
- FSM states IDLE, WRITE, READ.
  - IDLE → WRITE or READ on a legal header. The address is latched on the same edge.
  - WRITE/READ → IDLE on the next rx_data_ready, or on timeout.
- The timeout counter resets to 0 on entry to WRITE/READ and counts once per cycle.
  - When it equals FRAME_LOST_TIME: return to IDLE, pulse frame_lost_error, increment lost_cnt.
  - If rx_data_ready and the timeout coincide, the data word wins: the write is performed, with no error.
- Register map, R/W unless stated:
  - 0x01 board_id (RO, zero-extended).
  - 0x03 control.
  - 0x05 cpu_mode ([3:0]).
  - 0x1C illegal_cnt (RO).
  - 0x1D version[15:0] (RO).
  - 0x1E version[31:16] (RO).
  - 0x1F status {lost_cnt, clkerr_cnt}. Any write clears both counters.
  - 0x40 PWM period shadow.
  - 0x41+i width shadow for channel i, i < NUM_PWM.
  - 0x80+i rc_pwidth channel i (RO), i < NUM_RC.
  - 0xFF load: write-only, data ignored.
- Writes to RO or unmapped addresses are ignored. Reads of unmapped or write-only addresses return 0x0000.
- Reads of 0x40/0x41+i return the shadow value, not the active one.
- Writing 0xFF commits on one edge: all shadows copy to pwm_period/pwm_width, and load_pulse fires.
  - load_pulse is registered, so it is high in the cycle after the data word is sampled.
- All counters are 8-bit and saturate at 0xFF.
  - clkerr_cnt counts rising edges of spi_clk_error (one-stage edge detect).
  - A clear coinciding with an increment: the clear wins.

## Timing
- Reset values:
  - state IDLE.
  - tx_data 0, tx_data_ready 0.
  - cpu_mode 0, control 0.
  - pwm_period and its shadow = PWM_PERIOD_RST.
  - All widths and shadows = PWM_WIDTH_RST.
  - All counters 0.
  - load_pulse 0, frame_lost_error 0.
- Reset mid-frame: the transaction is aborted with no partial write.
- Read latency: the header is sampled at edge N.
  - At edge N+1, tx_data is loaded and tx_data_ready is set.
  - tx_data_ready is high for exactly cycle N+1..N+2.
  - tx_data holds its value until the next read loads a new one.
- Write: the register updates at the edge that samples the data word. The new value is visible on outputs the next cycle.
- Back-to-back frames: a header may arrive the cycle after the data word; IDLE accepts it immediately.
- frame_lost_error is registered: it is high in the cycle after the timeout edge.
- A header arriving in the same cycle as the timeout edge is not accepted.

## Test plan
- Reset: pwm_period=20000, every pwm_width channel=1500, all counters 0. Read 0x1F returns 0x0000.
- Double buffering:
  - Write 0x41←1800 and 0x40←10000: pwm_width ch0 and pwm_period are unchanged; a read of 0x41 returns 1800.
  - Write 0xFF: load_pulse fires once, ch0=1800, period=10000.
- Read: header 0xC005 after a cpu_mode write of 0x3. tx_data_ready is a single-cycle pulse one cycle after the header; tx_data=0x0003. A read of 0x80+NUM_RC returns 0x0000.
- Timeout:
  - Header 0x0003 with no data word: frame_lost_error pulses at cycle 2401 and control is unchanged.
  - A data word exactly at the timeout edge: the write lands and there is no pulse.
- Error counters:
  - 300 spi_clk_error rising edges: clkerr_cnt saturates at 0xFF.
  - Header 0x4001: illegal_cnt=1, state stays IDLE.
  - A write to 0x1F clears both counters.
- NUM_PWM=32, NUM_RC=16 build:
  - A write to 0x60 then 0xFF updates only ch31.
  - A read of 0x8F returns rc channel 15.
